sb_rx_msg_fifo: RTL and testbench
=================================

Name: sb_rx_msg_fifo

Overview:
- Buffers decoded sideband messages and their 64-bit payloads arriving from the sideband deserializer/decoder.
- Serves them one at a time to the LTSM sub-state blocks (SBINIT/MBINIT/...) through the available/req/valid pull handshake those blocks already use.
- Sits directly upstream of the LTSM state blocks, on clk_100MHz.
- Decouples bursty sideband arrivals from the LTSM's multi-cycle decision loop, so no message is lost while a state block is busy.

Parameters:
- DEPTH, 4, number of message entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk_100MHz  input  1  sideband-domain clock.
- reset  input  1  synchronous, active-high.
- enable_i  input  1  read-side enable; low freezes the pop side only.
- flush_i  input  1  synchronous clear of all contents, used on LTSM state change.
- SB_RX_in_msg_i  input  SB_msg_t  decoded message header from the decoder.
- SB_RX_in_data_i  input  64  payload accompanying the header.
- SB_RX_in_valid_i  input  1  one-cycle write strobe.
- SB_RX_msg_o  output  SB_msg_t  header of the most recently popped entry.
- SB_RX_dataBus_o  output  64  payload of the most recently popped entry.
- SB_RX_msg_available_o  output  1  high when occupancy is non-zero.
- SB_RX_msg_req_i  input  1  pop request from the consumer.
- SB_RX_msg_valid_o  output  1  one-cycle pulse: msg/data outputs updated.
- count_o  output  CNT_W  current occupancy.
- overflow_o  output  1  sticky flag: a message was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high, clock clk_100MHz):
  - wr_ptr, rd_ptr and count clear to 0.
  - SB_RX_msg_o = reset_SB_msg(), SB_RX_dataBus_o = 0.
  - SB_RX_msg_valid_o = 0, overflow_o = 0, available = 0.
  - Entry storage contents are don't-care.
- Storage: circular buffer of DEPTH entries, each {SB_msg_t, 64-bit data}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write: on a clock edge with SB_RX_in_valid_i=1 and space available, store the entry at wr_ptr and increment wr_ptr.
  - Space available means count<DEPTH, or a pop occurs on the same edge.
- Full drop: if SB_RX_in_valid_i=1, count==DEPTH and there is no same-edge pop, discard the entry.
  - Pointers and count are unchanged; overflow_o <= 1.
  - overflow_o stays set until reset or flush_i.
- Pop condition: enable_i && SB_RX_msg_req_i && count!=0 && !SB_RX_msg_valid_o.
  - On a pop, register the entry at rd_ptr onto SB_RX_msg_o/SB_RX_dataBus_o, increment rd_ptr and set SB_RX_msg_valid_o <= 1 for exactly one cycle.
  - The output registers hold their value until the next pop.
- Consumer handshake:
  - The consumer raises req one cycle after seeing available and drops it the cycle after sampling valid.
  - req is therefore still high during the valid cycle; the !valid_o guard ensures exactly one pop per request.
  - Pop latency: one edge from the first sampled req to valid high.
- Occupancy update per edge:
  - write only: count+1.
  - pop only: count-1.
  - write and pop: count unchanged, both pointers advance.
- SB_RX_msg_available_o = (count != 0), combinational from the count register; count_o = count.
- flush_i: highest priority after reset.
  - Clears pointers, count, valid_o and overflow_o.
  - A write or pop on the same edge is ignored.
  - Output message/data registers are not cleared.
- enable_i=0:
  - No pops and valid_o is forced to 0.
  - Writes and overflow detection continue, so messages arriving before the state block is enabled are retained.
- Reset mid-handshake: valid_o drops on the reset edge and no entry survives.
- No pop is possible when empty, even with req held high; valid_o stays 0.

Test Plan:
- Single message: write msg_num=MBINIT_PARAM_config_req with data 64'h1234_5678_9ABC_DEF0 → available=1 next cycle; the consumer's req yields valid 1 cycle later with matching header/data, count returns to 0, exactly one valid pulse even though req overlaps the valid cycle.
- Ordering/wrap: DEPTH=4, write 6 messages with msg_num sequence A..F, interleaving pops after every write from the 3rd onward → pops return A..F in order, pointers wrap past 3, overflow_o stays 0.
- Full drop: write 5 back-to-back with no req → count_o=4, overflow_o=1 after the 5th write, the 5th entry is never popped, the first 4 pop intact.
- Simultaneous write+pop at count=4: req pop and in_valid on the same edge → new entry accepted, count stays 4, overflow_o stays 0.
- enable_i low: write 2 messages with enable_i=0 and req=1 → no valid pulse, count_o=2; raise enable_i → 2 sequential pops, each a single valid pulse.
- Flush/reset: with count=3 and overflow=1, assert flush_i → count_o=0, available=0, overflow_o=0 next cycle; repeat with reset during a valid cycle → valid_o=0 and SB_RX_msg_o=reset_SB_msg().

Source files
------------

// File: rtl/sb_rx_msg_fifo_if.sv
// Sideband message types and the RX message FIFO bus interface.
// slave: FIFO side (write in, pull-handshake out); master: producer/consumer side.
package sb_pkg;

    typedef enum logic [4:0] {
        SB_MSG_NONE                = 5'd0,
        SBINIT_OOR_msg             = 5'd1,
        SBINIT_done_req            = 5'd2,
        SBINIT_done_resp           = 5'd3,
        MBINIT_PARAM_config_req    = 5'd4,
        MBINIT_PARAM_config_resp   = 5'd5,
        MBINIT_CAL_done_req        = 5'd6,
        MBINIT_CAL_done_resp       = 5'd7,
        MBINIT_REPAIRCLK_init_req  = 5'd8,
        MBINIT_REPAIRCLK_init_resp = 5'd9
    } sb_msg_num_e;

    typedef struct packed {
        sb_msg_num_e msg_num;
        logic [15:0] msg_info;
        logic [2:0]  src_id;
        logic [2:0]  dst_id;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.msg_num  = SB_MSG_NONE;
        m.msg_info = '0;
        m.src_id   = '0;
        m.dst_id   = '0;
        return m;
    endfunction

endpackage

interface sb_rx_msg_fifo_if;
    import sb_pkg::*;

    SB_msg_t     SB_RX_in_msg_i;
    logic [63:0] SB_RX_in_data_i;
    logic        SB_RX_in_valid_i;
    SB_msg_t     SB_RX_msg_o;
    logic [63:0] SB_RX_dataBus_o;
    logic        SB_RX_msg_available_o;
    logic        SB_RX_msg_req_i;
    logic        SB_RX_msg_valid_o;

    modport slave (
        input  SB_RX_in_msg_i,
        input  SB_RX_in_data_i,
        input  SB_RX_in_valid_i,
        input  SB_RX_msg_req_i,
        output SB_RX_msg_o,
        output SB_RX_dataBus_o,
        output SB_RX_msg_available_o,
        output SB_RX_msg_valid_o
    );

    modport master (
        output SB_RX_in_msg_i,
        output SB_RX_in_data_i,
        output SB_RX_in_valid_i,
        output SB_RX_msg_req_i,
        input  SB_RX_msg_o,
        input  SB_RX_dataBus_o,
        input  SB_RX_msg_available_o,
        input  SB_RX_msg_valid_o
    );

endinterface

// File: rtl/sb_rx_msg_fifo.sv
// RX sideband message FIFO: buffers decoded messages + payloads for the LTSM
// state blocks and serves them over the available/req/valid pull handshake.
// Ports: clk_100MHz, reset (sync, active-high), enable_i (pop-side enable),
// flush_i (sync clear), sb_if (slave modport: write strobe in, pull handshake
// out), count_o (occupancy), overflow_o (sticky drop flag).
module sb_rx_msg_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             flush_i,
    sb_rx_msg_fifo_if.slave  sb_if,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        SB_msg_t     msg;
        logic [63:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    SB_msg_t          msg_q, msg_d;
    logic [63:0]      data_q, data_d;

    logic full;
    logic pop;
    logic wr_en;

    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        // The !valid_q guard absorbs the consumer's req that is still high
        // during the valid cycle, giving exactly one pop per request.
        pop = enable_i && sb_if.SB_RX_msg_req_i
              && (count_q != '0) && !valid_q;
        // A same-edge pop frees the slot, so a full FIFO still accepts.
        wr_en = sb_if.SB_RX_in_valid_i && (!full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        msg_d    = msg_q;
        data_d   = data_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q].msg  = sb_if.SB_RX_in_msg_i;
                mem_d[wr_ptr_q].data = sb_if.SB_RX_in_data_i;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end

            if (sb_if.SB_RX_in_valid_i && !wr_en) begin
                ovf_d = 1'b1;
            end

            if (pop) begin
                msg_d    = mem_q[rd_ptr_q].msg;
                data_d   = mem_q[rd_ptr_q].data;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                valid_d  = 1'b1;
            end

            unique case ({wr_en, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            msg_q    <= reset_SB_msg();
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            msg_q    <= msg_d;
            data_q   <= data_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_100MHz) begin
        mem_q <= mem_d;
    end

    assign sb_if.SB_RX_msg_o           = msg_q;
    assign sb_if.SB_RX_dataBus_o       = data_q;
    assign sb_if.SB_RX_msg_available_o = (count_q != '0);
    assign sb_if.SB_RX_msg_valid_o     = valid_q;
    assign count_o                     = count_q;
    assign overflow_o                  = ovf_q;

endmodule

// File: tb/tb_sb_rx_msg_fifo.sv
// Directed table-driven bench for sb_rx_msg_fifo (DEPTH=4).
// Each vector: inputs for one edge, expected outputs after it.
module tb_sb_rx_msg_fifo;
    import sb_pkg::*;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       enable_i;
    logic       flush_i;
    logic [2:0] count_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    sb_rx_msg_fifo_if bus ();

    sb_rx_msg_fifo #(.DEPTH(4), .CNT_W(3)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enable_i   (enable_i),
        .flush_i    (flush_i),
        .sb_if      (bus),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        bit          en;
        bit          fl;
        bit          iv;
        bit          rq;
        sb_msg_num_e mn;
        logic [63:0] dat;
        int          cnt;
        bit          av;
        bit          vl;
        bit          ov;
        sb_msg_num_e omn;
        logic [63:0] odat;
    } vec_t;

    vec_t vq[$];

    localparam sb_msg_num_e N   = SB_MSG_NONE;
    localparam sb_msg_num_e CFG = MBINIT_PARAM_config_req;
    localparam sb_msg_num_e MA  = SBINIT_OOR_msg;
    localparam sb_msg_num_e MB  = SBINIT_done_req;
    localparam sb_msg_num_e MC  = SBINIT_done_resp;
    localparam sb_msg_num_e MD  = MBINIT_PARAM_config_resp;
    localparam sb_msg_num_e ME  = MBINIT_CAL_done_req;
    localparam sb_msg_num_e MF  = MBINIT_CAL_done_resp;
    localparam logic [63:0] D0  = 64'h1234_5678_9ABC_DEF0;

    function automatic SB_msg_t mk(sb_msg_num_e mn);
        SB_msg_t m;
        if (mn == SB_MSG_NONE) return reset_SB_msg();
        m.msg_num  = mn;
        m.msg_info = 16'hC000 | 16'(mn);
        m.src_id   = 3'd1;
        m.dst_id   = 3'd2;
        return m;
    endfunction

    function automatic void v(bit en, bit fl, bit iv, bit rq,
                              sb_msg_num_e mn, logic [63:0] dat,
                              int cnt, bit av, bit vl, bit ov,
                              sb_msg_num_e omn, logic [63:0] odat);
        vec_t t;
        t.en = en; t.fl = fl; t.iv = iv; t.rq = rq;
        t.mn = mn; t.dat = dat;
        t.cnt = cnt; t.av = av; t.vl = vl; t.ov = ov;
        t.omn = omn; t.odat = odat;
        vq.push_back(t);
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk_out(string p, int cnt, bit av, bit vl, bit ov,
                           SB_msg_t m, logic [63:0] d);
        chk({p, ".count"}, 128'(count_o), 128'(cnt));
        chk({p, ".avail"}, 128'(bus.SB_RX_msg_available_o), 128'(av));
        chk({p, ".valid"}, 128'(bus.SB_RX_msg_valid_o), 128'(vl));
        chk({p, ".ovf"}, 128'(overflow_o), 128'(ov));
        chk({p, ".msg"}, 128'(bus.SB_RX_msg_o), 128'(m));
        chk({p, ".data"}, 128'(bus.SB_RX_dataBus_o), 128'(d));
    endtask

    task automatic idle_inputs();
        enable_i             = 1'b1;
        flush_i              = 1'b0;
        bus.SB_RX_in_valid_i = 1'b0;
        bus.SB_RX_msg_req_i  = 1'b0;
        bus.SB_RX_in_msg_i   = reset_SB_msg();
        bus.SB_RX_in_data_i  = '0;
    endtask

    initial begin
        // single message; req overlaps the valid cycle
        v(1,0,1,0,CFG,D0,   1,1,0,0, N,0);
        v(1,0,0,1,N,0,      0,0,1,0, CFG,D0);
        v(1,0,0,1,N,0,      0,0,0,0, CFG,D0);
        v(1,0,0,0,N,0,      0,0,0,0, CFG,D0);
        // ordering and pointer wrap
        v(1,0,1,0,MA,64'hA, 1,1,0,0, CFG,D0);
        v(1,0,1,0,MB,64'hB, 2,1,0,0, CFG,D0);
        v(1,0,1,1,MC,64'hC, 2,1,1,0, MA,64'hA);
        v(1,0,1,1,MD,64'hD, 3,1,0,0, MA,64'hA);
        v(1,0,1,1,ME,64'hE, 3,1,1,0, MB,64'hB);
        v(1,0,1,1,MF,64'hF, 4,1,0,0, MB,64'hB);
        v(1,0,0,1,N,0,      3,1,1,0, MC,64'hC);
        v(1,0,0,1,N,0,      3,1,0,0, MC,64'hC);
        v(1,0,0,1,N,0,      2,1,1,0, MD,64'hD);
        v(1,0,0,1,N,0,      2,1,0,0, MD,64'hD);
        v(1,0,0,1,N,0,      1,1,1,0, ME,64'hE);
        v(1,0,0,1,N,0,      1,1,0,0, ME,64'hE);
        v(1,0,0,1,N,0,      0,0,1,0, MF,64'hF);
        v(1,0,0,1,N,0,      0,0,0,0, MF,64'hF);
        // full drop; 5th entry never popped
        v(1,0,1,0,MA,64'h11, 1,1,0,0, MF,64'hF);
        v(1,0,1,0,MB,64'h12, 2,1,0,0, MF,64'hF);
        v(1,0,1,0,MC,64'h13, 3,1,0,0, MF,64'hF);
        v(1,0,1,0,MD,64'h14, 4,1,0,0, MF,64'hF);
        v(1,0,1,0,ME,64'h15, 4,1,0,1, MF,64'hF);
        v(1,0,0,1,N,0,       3,1,1,1, MA,64'h11);
        v(1,0,0,1,N,0,       3,1,0,1, MA,64'h11);
        v(1,0,0,1,N,0,       2,1,1,1, MB,64'h12);
        v(1,0,0,1,N,0,       2,1,0,1, MB,64'h12);
        v(1,0,0,1,N,0,       1,1,1,1, MC,64'h13);
        v(1,0,0,1,N,0,       1,1,0,1, MC,64'h13);
        v(1,0,0,1,N,0,       0,0,1,1, MD,64'h14);
        v(1,0,0,1,N,0,       0,0,0,1, MD,64'h14);
        // flush at count=3, overflow=1; same-edge write/pop ignored
        v(1,0,1,0,MA,64'h41, 1,1,0,1, MD,64'h14);
        v(1,0,1,0,MB,64'h42, 2,1,0,1, MD,64'h14);
        v(1,0,1,0,MC,64'h43, 3,1,0,1, MD,64'h14);
        v(1,1,1,1,MD,64'h44, 0,0,0,0, MD,64'h14);
        v(1,0,0,0,N,0,       0,0,0,0, MD,64'h14);
        // simultaneous write+pop at count=4
        v(1,0,1,0,MA,64'h21, 1,1,0,0, MD,64'h14);
        v(1,0,1,0,MB,64'h22, 2,1,0,0, MD,64'h14);
        v(1,0,1,0,MC,64'h23, 3,1,0,0, MD,64'h14);
        v(1,0,1,0,MD,64'h24, 4,1,0,0, MD,64'h14);
        v(1,0,1,1,ME,64'h25, 4,1,1,0, MA,64'h21);
        v(1,0,0,1,N,0,       4,1,0,0, MA,64'h21);
        v(1,0,0,1,N,0,       3,1,1,0, MB,64'h22);
        v(1,0,0,1,N,0,       3,1,0,0, MB,64'h22);
        v(1,0,0,1,N,0,       2,1,1,0, MC,64'h23);
        v(1,0,0,1,N,0,       2,1,0,0, MC,64'h23);
        v(1,0,0,1,N,0,       1,1,1,0, MD,64'h24);
        v(1,0,0,1,N,0,       1,1,0,0, MD,64'h24);
        v(1,0,0,1,N,0,       0,0,1,0, ME,64'h25);
        v(1,0,0,0,N,0,       0,0,0,0, ME,64'h25);
        // enable low retains writes, blocks pops
        v(0,0,1,1,MA,64'h31, 1,1,0,0, ME,64'h25);
        v(0,0,1,1,MB,64'h32, 2,1,0,0, ME,64'h25);
        v(0,0,0,1,N,0,       2,1,0,0, ME,64'h25);
        v(1,0,0,1,N,0,       1,1,1,0, MA,64'h31);
        v(1,0,0,1,N,0,       1,1,0,0, MA,64'h31);
        v(1,0,0,1,N,0,       0,0,1,0, MB,64'h32);
        v(1,0,0,0,N,0,       0,0,0,0, MB,64'h32);

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk_out("reset", 0, 0, 0, 0, reset_SB_msg(), 64'h0);
        reset = 1'b0;

        foreach (vq[i]) begin
            enable_i             = vq[i].en;
            flush_i              = vq[i].fl;
            bus.SB_RX_in_valid_i = vq[i].iv;
            bus.SB_RX_msg_req_i  = vq[i].rq;
            bus.SB_RX_in_msg_i   = mk(vq[i].mn);
            bus.SB_RX_in_data_i  = vq[i].dat;
            step();
            chk_out($sformatf("v%0d", i), vq[i].cnt, vq[i].av,
                    vq[i].vl, vq[i].ov, mk(vq[i].omn), vq[i].odat);
        end
        idle_inputs();

        // reset during a valid cycle with entries still queued
        bus.SB_RX_in_valid_i = 1'b1;
        bus.SB_RX_in_msg_i   = mk(MC);
        bus.SB_RX_in_data_i  = 64'h51;
        step();
        bus.SB_RX_in_msg_i   = mk(MD);
        bus.SB_RX_in_data_i  = 64'h52;
        step();
        bus.SB_RX_in_valid_i = 1'b0;
        bus.SB_RX_msg_req_i  = 1'b1;
        step();
        chk_out("rst_pre", 1, 1, 1, 0, mk(MC), 64'h51);
        reset = 1'b1;
        step();
        chk_out("rst_mid", 0, 0, 0, 0, reset_SB_msg(), 64'h0);
        reset = 1'b0;
        step();
        chk_out("rst_post", 0, 0, 0, 0, reset_SB_msg(), 64'h0);
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
